next_pc_gen: RTL and testbench

NEXT_PC_GEN -- requirements
Module: next_pc_gen

---
 rtl/next_pc_gen_pkg.sv | 47 ++++
 rtl/next_pc_gen_if.sv | 38 +++
 rtl/next_pc_gen_ras.sv | 60 ++++++
 rtl/next_pc_gen.sv | 97 +++++++++
 tb/tb_next_pc_gen.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/next_pc_gen_pkg.sv
// Shared definitions for the next-PC generator: parameter defaults, FSM states
// and the control-priority select encoding.
package next_pc_gen_pkg;

    localparam int PC_W_DEF      = 8;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_HOLD,
        SEL_HALT,
        SEL_RET,
        SEL_CALL,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_SEQ
    } ctrl_sel_e;

    // Priority: Stall > Halt > Ret > Call > Jump > taken branch > sequential.
    function automatic ctrl_sel_e select_ctrl(
        input state_e st,
        input logic   stall,
        input logic   halt,
        input logic   ret,
        input logic   call,
        input logic   jump,
        input logic   br_taken
    );
        ctrl_sel_e sel;
        if (st == ST_BOOT)                   sel = SEL_ZERO;
        else if (st == ST_HALT || stall)     sel = SEL_HOLD;
        else if (halt)                       sel = SEL_HALT;
        else if (ret)                        sel = SEL_RET;
        else if (call)                       sel = SEL_CALL;
        else if (jump)                       sel = SEL_JUMP;
        else if (br_taken)                   sel = SEL_BRANCH;
        else                                 sel = SEL_SEQ;
        return sel;
    endfunction

endpackage

// File: rtl/next_pc_gen_if.sv
// Control/PC bundle between the fetch stage and the next-PC generator.
interface next_pc_gen_if
    import next_pc_gen_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) ();

    localparam int DEPTH_W = $clog2(RAS_DEPTH) + 1;

    logic [PC_W-1:0]    PCin;
    logic               Stall;
    logic               Branch;
    logic               BranchTaken;
    logic [PC_W-1:0]    BranchOff;
    logic               Jump;
    logic               Call;
    logic [PC_W-1:0]    JumpAddr;
    logic               Ret;
    logic               Halt;
    logic [PC_W-1:0]    NewPC;
    logic               Halted;
    logic               StackErr;
    logic [DEPTH_W-1:0] StackDepth;

    modport master (
        output PCin, Stall, Branch, BranchTaken, BranchOff,
               Jump, Call, JumpAddr, Ret, Halt,
        input  NewPC, Halted, StackErr, StackDepth
    );

    modport slave (
        input  PCin, Stall, Branch, BranchTaken, BranchOff,
               Jump, Call, JumpAddr, Ret, Halt,
        output NewPC, Halted, StackErr, StackDepth
    );

endinterface

// File: rtl/next_pc_gen_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// RAS_DEPTH must be a power of two, at least 2.
module npc_ras
    import next_pc_gen_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [PC_W-1:0]              push_data_i,
    output logic [PC_W-1:0]              top_o,
    output logic [$clog2(RAS_DEPTH):0]   depth_o,
    output logic                         err_o
);

    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;

    logic [PC_W-1:0]    mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DEPTH_W-1:0] depth_q;
    logic               err_q;
    logic               full;
    logic               empty;

    // When full the write pointer already sits on the oldest entry.
    assign rd_ptr = wr_ptr_q - PTR_W'(1);
    assign full   = (depth_q == DEPTH_W'(RAS_DEPTH));
    assign empty  = (depth_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            depth_q  <= '0;
            err_q    <= 1'b0;
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            if (full) err_q   <= 1'b1;
            else      depth_q <= depth_q + DEPTH_W'(1);
        end else if (pop_i) begin
            if (empty) begin
                err_q <= 1'b1;
            end else begin
                wr_ptr_q <= rd_ptr;
                depth_q  <= depth_q - DEPTH_W'(1);
            end
        end
    end

    assign top_o   = mem_q[rd_ptr];
    assign depth_o = depth_q;
    assign err_o   = err_q;

endmodule

// File: rtl/next_pc_gen.sv
// Next-PC generator with BOOT/RUN/HALT control FSM.
// Define NPC_RAS_EN to include the return-address stack (npc_ras).
module next_pc_gen
    import next_pc_gen_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    next_pc_gen_if.slave  bus
);

    localparam int DEPTH_W = $clog2(RAS_DEPTH) + 1;

    state_e             state_q;
    logic               halted_q;
    ctrl_sel_e          sel;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    pc_br;
    logic [PC_W-1:0]    new_pc;
    logic [PC_W-1:0]    ras_top;
    logic [DEPTH_W-1:0] ras_depth;
    logic               ras_err;

    assign sel    = select_ctrl(state_q, bus.Stall, bus.Halt, bus.Ret, bus.Call,
                                bus.Jump, bus.Branch & bus.BranchTaken);
    assign pc_inc = bus.PCin + PC_W'(1);
    assign pc_br  = pc_inc + bus.BranchOff;

`ifdef NPC_RAS_EN
    logic ras_push;
    logic ras_pop;

    assign ras_push = (sel == SEL_CALL);
    assign ras_pop  = (sel == SEL_RET);

    npc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .depth_o     (ras_depth),
        .err_o       (ras_err)
    );
`else
    assign ras_top   = '0;
    assign ras_depth = '0;
    assign ras_err   = 1'b0;
`endif

    // Without the stack the depth is always zero, so Ret falls to PCin+1.
    always_comb begin
        new_pc = pc_inc;
        case (sel)
            SEL_ZERO:           new_pc = '0;
            SEL_HOLD, SEL_HALT: new_pc = bus.PCin;
            SEL_RET:            new_pc = (ras_depth != '0) ? ras_top : pc_inc;
            SEL_CALL, SEL_JUMP: new_pc = bus.JumpAddr;
            SEL_BRANCH:         new_pc = pc_br;
            default:            new_pc = pc_inc;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_BOOT;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (sel == SEL_HALT) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALT: ;
                default: begin
                    state_q  <= ST_BOOT;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.NewPC      = new_pc;
    assign bus.Halted     = halted_q;
    assign bus.StackErr   = ras_err;
    assign bus.StackDepth = ras_depth;

endmodule

// File: tb/tb_next_pc_gen.sv
// Self-checking bench for next_pc_gen: directed table, hand sequences and
// randomized cycles against a queue-based reference model.
module tb_next_pc_gen;

    localparam int PC_W      = 8;
    localparam int RAS_DEPTH = 4;
`ifdef NPC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] pc;
        logic       stall;
        logic       branch;
        logic       taken;
        logic [7:0] off;
        logic       jump;
        logic       call;
        logic [7:0] jaddr;
        logic       ret;
        logic       halt;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [7:0] exp_pc;
    } vec_t;

    logic CLK;
    logic RST;

    next_pc_gen_if #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

    next_pc_gen #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: 0=BOOT 1=RUN 2=HALT, stack as a queue (back = top).
    int         mstate = 0;
    logic [7:0] mstack[$];
    bit         merr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t idle(input logic [7:0] pc);
        in_t v;
        v.pc = pc; v.stall = 0; v.branch = 0; v.taken = 0; v.off = 8'h00;
        v.jump = 0; v.call = 0; v.jaddr = 8'h00; v.ret = 0; v.halt = 0;
        return v;
    endfunction

    function automatic logic [7:0] model_pc(input in_t v);
        logic [7:0] pc1;
        pc1 = v.pc + 8'd1;
        if (mstate == 0) return 8'h00;
        if (mstate == 2 || v.stall || v.halt) return v.pc;
        if (v.ret) return (RAS_ON && mstack.size() > 0) ? mstack[$] : pc1;
        if (v.call || v.jump) return v.jaddr;
        if (v.branch && v.taken) return pc1 + v.off;
        return pc1;
    endfunction

    task automatic model_update(input logic r, input in_t v);
        logic [7:0] dummy;
        if (r) begin
            mstate = 0;
            mstack.delete();
            merr = 1'b0;
        end else if (mstate == 0) begin
            mstate = 1;
        end else if (mstate == 1 && !v.stall) begin
            if (v.halt) begin
                mstate = 2;
            end else if (v.ret) begin
                if (RAS_ON) begin
                    if (mstack.size() > 0) dummy = mstack.pop_back();
                    else merr = 1'b1;
                end
            end else if (v.call && RAS_ON) begin
                mstack.push_back(v.pc + 8'd1);
                if (mstack.size() > RAS_DEPTH) begin
                    dummy = mstack.pop_front();
                    merr = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle; optionally compare against model and a fixed NewPC.
    task automatic step(input logic r, input in_t v, input bit do_chk,
                        input string tag, input int exp_pc);
        RST             = r;
        bus.PCin        = v.pc;
        bus.Stall       = v.stall;
        bus.Branch      = v.branch;
        bus.BranchTaken = v.taken;
        bus.BranchOff   = v.off;
        bus.Jump        = v.jump;
        bus.Call        = v.call;
        bus.JumpAddr    = v.jaddr;
        bus.Ret         = v.ret;
        bus.Halt        = v.halt;
        #2;
        if (do_chk) begin
            chk({tag, ".NewPC"}, 32'(bus.NewPC), 32'(model_pc(v)));
            chk({tag, ".Halted"}, 32'(bus.Halted), 32'(mstate == 2));
            chk({tag, ".StackDepth"}, 32'(bus.StackDepth), 32'(mstack.size()));
            chk({tag, ".StackErr"}, 32'(bus.StackErr), 32'(merr));
            if (exp_pc >= 0) chk({tag, ".NewPC_fixed"}, 32'(bus.NewPC), 32'(exp_pc));
        end
        @(posedge CLK);
        model_update(r, v);
        #1;
    endtask

    vec_t table_v[$];

    function automatic vec_t mk(input string name, input in_t in, input logic [7:0] exp_pc);
        vec_t t;
        t.name = name; t.in = in; t.exp_pc = exp_pc;
        return t;
    endfunction

    initial begin
        in_t v;

        v = idle(8'h10); v.branch = 1; v.taken = 1; v.off = 8'hFC;
        table_v.push_back(mk("br_taken_neg", v, 8'h0D));
        v.taken = 0;
        table_v.push_back(mk("br_not_taken", v, 8'h11));
        table_v.push_back(mk("seq_wrap", idle(8'hFF), 8'h00));
        v = idle(8'hF0); v.branch = 1; v.taken = 1; v.off = 8'h20;
        table_v.push_back(mk("br_taken_wrap", v, 8'h11));
        v = idle(8'h07); v.taken = 1; v.off = 8'h10;
        table_v.push_back(mk("taken_no_branch", v, 8'h08));
        v = idle(8'h33); v.jump = 1; v.jaddr = 8'h9A;
        table_v.push_back(mk("jump", v, 8'h9A));
        v.branch = 1; v.taken = 1; v.off = 8'h05;
        table_v.push_back(mk("jump_over_branch", v, 8'h9A));
        v = idle(8'h44); v.stall = 1; v.jump = 1; v.jaddr = 8'h01;
        table_v.push_back(mk("stall_over_jump", v, 8'h44));
        v = idle(8'h44); v.stall = 1; v.branch = 1; v.taken = 1; v.off = 8'h02;
        table_v.push_back(mk("stall_over_branch", v, 8'h44));

        // Reset then release: BOOT ignores controls for one cycle.
        step(1'b1, idle(8'h00), 1'b0, "rst0", -1);
        step(1'b1, idle(8'h00), 1'b1, "rst1", 0);
        v = idle(8'h00); v.jump = 1; v.jaddr = 8'h77;
        step(1'b0, v, 1'b1, "boot", 0);
        step(1'b0, idle(8'h05), 1'b1, "seq", 8'h06);

        foreach (table_v[i]) step(1'b0, table_v[i].in, 1'b1, table_v[i].name, int'(table_v[i].exp_pc));

`ifdef NPC_RAS_EN
        v = idle(8'h20); v.call = 1; v.jaddr = 8'h80;
        step(1'b0, v, 1'b1, "call", 8'h80);
        chk("call.depth1", 32'(bus.StackDepth), 32'd1);
        v = idle(8'h85); v.ret = 1; v.call = 1; v.jaddr = 8'hEE;
        step(1'b0, v, 1'b1, "ret_over_call", 8'h21);
        chk("ret.depth0", 32'(bus.StackDepth), 32'd0);

        for (int i = 1; i <= 5; i++) begin
            v = idle(8'(i)); v.call = 1; v.jaddr = 8'h50;
            step(1'b0, v, 1'b1, "call5", 8'h50);
        end
        chk("ovf.err", 32'(bus.StackErr), 32'd1);
        chk("ovf.depth", 32'(bus.StackDepth), 32'd4);
        for (int k = 0; k < 4; k++) begin
            v = idle(8'h50); v.ret = 1;
            step(1'b0, v, 1'b1, "ret4", 6 - k);
        end
        v = idle(8'h40); v.ret = 1;
        step(1'b0, v, 1'b1, "ret_empty", 8'h41);
        chk("unf.err_sticky", 32'(bus.StackErr), 32'd1);
        chk("unf.depth", 32'(bus.StackDepth), 32'd0);
`else
        v = idle(8'h20); v.call = 1; v.jaddr = 8'h30;
        step(1'b0, v, 1'b1, "call_as_jump", 8'h30);
        chk("noras.depth", 32'(bus.StackDepth), 32'd0);
        chk("noras.err", 32'(bus.StackErr), 32'd0);
        v = idle(8'h40); v.ret = 1;
        step(1'b0, v, 1'b1, "ret_noras", 8'h41);
`endif

        // Halt is masked by stall, then taken; HALT ignores controls until reset.
        v = idle(8'h12); v.halt = 1; v.stall = 1;
        step(1'b0, v, 1'b1, "halt_stalled", 8'h12);
        chk("halt_stalled.halted", 32'(bus.Halted), 32'd0);
        v.stall = 0;
        step(1'b0, v, 1'b1, "halt", 8'h12);
        chk("halt.halted", 32'(bus.Halted), 32'd1);
        v = idle(8'h34); v.jump = 1; v.jaddr = 8'h99; v.ret = 1; v.call = 1;
        step(1'b0, v, 1'b1, "halt_ignore", 8'h34);
        step(1'b1, idle(8'h55), 1'b1, "rst_in_halt", 8'h55);
        chk("rst_halt.halted", 32'(bus.Halted), 32'd0);
        chk("rst_halt.err", 32'(bus.StackErr), 32'd0);
        step(1'b0, idle(8'h55), 1'b1, "boot2", 0);
        step(1'b0, idle(8'h03), 1'b1, "run2", 8'h04);
        v = idle(8'h08); v.call = 1; v.jaddr = 8'hA0;
        step(1'b1, v, 1'b1, "rst_mid_call", 8'hA0);
        chk("rst_call.depth", 32'(bus.StackDepth), 32'd0);
        step(1'b0, idle(8'h00), 1'b1, "boot3", 0);

        for (int n = 0; n < 3000; n++) begin
            logic r;
            v.pc     = 8'($urandom);
            v.stall  = ($urandom_range(0, 5) == 0);
            v.branch = 1'($urandom_range(0, 1));
            v.taken  = 1'($urandom_range(0, 1));
            v.off    = 8'($urandom);
            v.jump   = ($urandom_range(0, 5) == 0);
            v.call   = ($urandom_range(0, 3) == 0);
            v.jaddr  = 8'($urandom);
            v.ret    = ($urandom_range(0, 3) == 0);
            v.halt   = ($urandom_range(0, 60) == 0);
            r        = ($urandom_range(0, 80) == 0);
            step(r, v, 1'b1, "rnd", -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
